// File: rtl/lu_word_driver.sv
// Word-serial driver for a combinational 1-bit logic unit: accepts an operand pair and opcode,
// walks the bits LSB first over lu_a/lu_b/lu_s, and returns the collected result word.
// Optional build macro: LU_OP3_BYPASS_EN (opcode 3 completes immediately with a zero result).
module lu_word_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             lu_a,
  output logic             lu_b,
  output logic [1:0]       lu_s,
  input  logic             lu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             lu_a_q, lu_a_d;
  logic             lu_b_q, lu_b_d;
  logic [1:0]       lu_s_q, lu_s_d;

  // Next-state and output decode; LU pins are loaded one edge ahead of the bit being sampled.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    res_d       = res_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    lu_a_d      = lu_a_q;
    lu_b_d      = lu_b_q;
    lu_s_d      = lu_s_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = in_b;
          op_d       = in_op;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
          lu_a_d     = in_a[0];
          lu_b_d     = in_b[0];
          lu_s_d     = in_op;
`ifdef LU_OP3_BYPASS_EN
          if (in_op == 2'b11) begin
            state_d = DONE;
            out_y_d = '0;
            lu_a_d  = 1'b0;
            lu_b_d  = 1'b0;
            lu_s_d  = 2'b00;
          end
`endif
        end
      end
      RUN: begin
        res_d[cnt_q] = lu_y;
        if (cnt_q == LAST) begin
          state_d = DONE;
          out_y_d = res_d;
          lu_a_d  = 1'b0;
          lu_b_d  = 1'b0;
          lu_s_d  = 2'b00;
        end else begin
          cnt_d  = cnt_q + CW'(1);
          lu_a_d = a_q[cnt_d];
          lu_b_d = b_q[cnt_d];
          lu_s_d = op_q;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 2'b00;
      res_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      lu_a_q      <= 1'b0;
      lu_b_q      <= 1'b0;
      lu_s_q      <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      lu_a_q      <= lu_a_d;
      lu_b_q      <= lu_b_d;
      lu_s_q      <= lu_s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign lu_a      = lu_a_q;
  assign lu_b      = lu_b_q;
  assign lu_s      = lu_s_q;

endmodule

// File: tb/tb_lu_word_driver.sv
// Bench for lu_word_driver: table vectors, hand-written corner sequences and random commands
// checked against a word-level model of the 1-bit LU (AND, OR, XOR, zero).
module tb_lu_word_driver;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         lu_a;
  logic         lu_b;
  logic [1:0]   lu_s;
  logic         lu_y;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;

  int n_cmp = 0;
  int n_err = 0;

  lu_word_driver #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_s(lu_s), .lu_y(lu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
  );

  always #5 clk = ~clk;

  // External combinational 1-bit LU
  always_comb begin
    case (lu_s)
      2'd0:    lu_y = lu_a & lu_b;
      2'd1:    lu_y = lu_a | lu_b;
      2'd2:    lu_y = lu_a ^ lu_b;
      default: lu_y = 1'b0;
    endcase
  end

  function automatic logic [W-1:0] ref_word(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op);
`ifdef LU_OP3_BYPASS_EN
    if (op == 2'b11) return 1;
`endif
    return W + 1;
  endfunction

  function automatic bit is_bypass(input logic [1:0] op);
`ifdef LU_OP3_BYPASS_EN
    return op == 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, collect the result, hold it for 'hold' cycles, then release it.
  task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input int hold, input logic [W-1:0] exp_y);
    logic [W-1:0] seq_a, seq_b, y;
    logic         s_ok;
    int           lat;
    chk("in_ready_before_cmd", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); in_op = 2'($urandom);
    lat = 0; seq_a = '0; seq_b = '0; s_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (lat < int'(W)) begin
        seq_a[lat] = lu_a;
        seq_b[lat] = lu_b;
        if (lu_s !== (is_bypass(op) ? 2'b00 : op)) s_ok = 1'b0;
      end
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_latency(op)));
    chk("out_y", 64'(out_y), 64'(exp_y));
    chk("lu_a_sequence", 64'(seq_a), is_bypass(op) ? 64'd0 : 64'(a));
    chk("lu_b_sequence", 64'(seq_b), is_bypass(op) ? 64'd0 : 64'(b));
    chk("lu_s_during_run", 64'(s_ok), 64'd1);
    y = out_y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      tick();
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_out_y", 64'(out_y), 64'(y));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_lu_pins", 64'({lu_a, lu_b, lu_s}), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 8'hC5, b: 8'h3A, op: 2'd2, y: 8'hFF};
    vecs[1] = '{a: 8'hF0, b: 8'h3C, op: 2'd0, y: 8'h30};
    vecs[2] = '{a: 8'hF0, b: 8'h3C, op: 2'd1, y: 8'hFC};
    vecs[3] = '{a: 8'hAA, b: 8'h55, op: 2'd3, y: 8'h00};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, op: 2'd2, y: 8'h00};
    vecs[5] = '{a: 8'h81, b: 8'h01, op: 2'd0, y: 8'h01};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'd0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_y", 64'(out_y), 64'd0);
    chk("reset_lu_pins", 64'({lu_a, lu_b, lu_s}), 64'd0);

    foreach (vecs[i]) do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, 0, vecs[i].y);

    // Long back-pressure with in_valid asserted, then an immediate follow-up command
    do_cmd(8'h5A, 8'h0F, 2'd1, 5, 8'h5F);
    do_cmd(8'h3C, 8'h0F, 2'd2, 0, 8'h33);

    // Reset while bit 3 is on the LU pins
    in_a = 8'hFF; in_b = 8'h0F; in_op = 2'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_abort_lu_a_bit3", 64'(lu_a), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_out_y", 64'(out_y), 64'd0);
    chk("abort_lu_pins", 64'({lu_a, lu_b, lu_s}), 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (out_valid !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic [1:0]   op;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      do_cmd(a, b, op, int'($urandom_range(0, 3)), ref_word(a, b, op));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
